// File: rtl/ierl78_icedop_pkg.sv
// Shared types and constants for the ICEDOP reader.
// State encoding, wait bounds and bus geometry.
package ierl78_icedop_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STRB = 1'b1
  } state_e;

  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned SEL_BIT  = 7;
  localparam int unsigned DATA_W   = 32;

endpackage

// File: rtl/ierl78_icedop_fifo2.sv
// Two-entry FIFO holding returned ICEDOP words.
// Output is forced to zero while empty.
module ierl78_icedop_fifo2
  import ierl78_icedop_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              vld,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop  = pop & (cnt_q != 2'd0);
    do_push = push & (cnt_q != 2'd2);
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wp_q] = din;
      wp_d        = ~wp_q;
    end
    if (do_pop) begin
      rp_d = ~rp_q;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign vld   = (cnt_q != 2'd0);
  assign dout  = vld ? mem_q[rp_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/ierl78_icedop_reader.sv
// Strobed reader for the OR-combined ICEDOP bus with a
// two-deep return buffer and a sticky idle-bus error flag.
module ierl78_icedop_reader
  import ierl78_icedop_pkg::*;
#(
  parameter int unsigned WAIT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RDREQ,
  input  logic [7:0]        RDADDR,
  output logic              RDACK,
  output logic [6:0]        ICEADR,
  output logic              ICERDA,
  output logic              ICERDB,
  input  logic [DATA_W-1:0] ICEDOP,
  output logic [DATA_W-1:0] RDDATA,
  output logic              RDVLD,
  input  logic              RDRDY,
  input  logic              CLRERR,
  output logic              ORERR
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  adr_q, adr_d;
  logic        rda_q, rda_d;
  logic        rdb_q, rdb_d;
  logic        idle_q, idle_d;
  logic        err_q, err_d;
  logic        push;
  logic        err_set;
  logic [1:0]  fifo_cnt;

  assign RDACK = RDREQ & ~RST & (state_q == ST_IDLE)
               & (fifo_cnt < 2'd2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    rda_d   = rda_q;
    rdb_d   = rdb_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (RDACK) begin
          state_d = ST_STRB;
          cnt_d   = 4'(WAIT - 1);
          adr_d   = RDADDR[6:0];
          rda_d   = ~RDADDR[SEL_BIT];
          rdb_d   = RDADDR[SEL_BIT];
        end
      end
      ST_STRB: begin
        if (cnt_q == 4'd0) begin
          push    = ~RST;
          rda_d   = 1'b0;
          rdb_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // The first idle cycle after a strobe tolerates a draining bus.
  always_comb begin
    idle_d  = (state_q == ST_IDLE);
    err_set = (state_q == ST_IDLE) & idle_q & (|ICEDOP);
    err_d   = err_set | (err_q & ~CLRERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 7'd0;
      rda_q   <= 1'b0;
      rdb_q   <= 1'b0;
      idle_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  ierl78_icedop_fifo2 u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   (ICEDOP),
    .pop   (RDRDY),
    .dout  (RDDATA),
    .vld   (RDVLD),
    .count (fifo_cnt)
  );

  assign ICEADR = adr_q;
  assign ICERDA = rda_q;
  assign ICERDB = rdb_q;
  assign ORERR  = err_q;

endmodule

// File: tb/tb_ierl78_icedop_reader.sv
// Directed bench for the ICEDOP reader.
// Sources are modelled as strobe-gated drivers on the OR bus.
module tb_ierl78_icedop_reader;

  logic        clk;
  logic        rst;
  logic        rdreq;
  logic [7:0]  rdaddr;
  logic        rdack;
  logic [6:0]  iceadr;
  logic        icerda;
  logic        icerdb;
  logic [31:0] icedop;
  logic [31:0] rddata;
  logic        rdvld;
  logic        rdrdy;
  logic        clrerr;
  logic        orerr;

  logic [31:0] a_data;
  logic [31:0] b_data;
  logic [31:0] force_v;
  logic        tag_mode;

  int n_chk = 0;
  int n_err = 0;

  ierl78_icedop_reader #(.WAIT(2)) dut (
    .CLK    (clk),
    .RST    (rst),
    .RDREQ  (rdreq),
    .RDADDR (rdaddr),
    .RDACK  (rdack),
    .ICEADR (iceadr),
    .ICERDA (icerda),
    .ICERDB (icerdb),
    .ICEDOP (icedop),
    .RDDATA (rddata),
    .RDVLD  (rdvld),
    .RDRDY  (rdrdy),
    .CLRERR (clrerr),
    .ORERR  (orerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    icedop = force_v;
    if (icerda)
      icedop = icedop | (tag_mode ?
        (32'hC0DE_0000 | {25'd0, iceadr}) : a_data);
    if (icerdb)
      icedop = icedop | (tag_mode ?
        (32'hD0DE_0000 | {25'd0, iceadr}) : b_data);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1; rdreq = 1; rdaddr = 8'h05;
    rdrdy = 0; clrerr = 0; force_v = 0;
    tag_mode = 0; a_data = 0; b_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_ack", rdack, 0);
    chk("rst_rda", icerda, 0);
    chk("rst_rdb", icerdb, 0);
    chk("rst_adr", iceadr, 0);
    chk("rst_vld", rdvld, 0);
    chk("rst_data", rddata, 0);
    chk("rst_err", orerr, 0);
    rdreq = 0; rst = 0;
    repeat (3) @(negedge clk);
    chk("idle_err", orerr, 0);

    // Source A read
    a_data = 32'hA5A5_0001; rdaddr = 8'h05; rdreq = 1;
    #1 chk("a_ack", rdack, 1);
    @(negedge clk); rdreq = 0;
    chk("a_rda1", icerda, 1);
    chk("a_rdb1", icerdb, 0);
    chk("a_adr", iceadr, 7'h05);
    chk("a_vld1", rdvld, 0);
    @(negedge clk);
    chk("a_rda2", icerda, 1);
    chk("a_vld2", rdvld, 0);
    @(negedge clk);
    chk("a_rda3", icerda, 0);
    chk("a_vld3", rdvld, 1);
    chk("a_data", rddata, 32'hA5A5_0001);
    @(negedge clk);
    chk("a_hold", rddata, 32'hA5A5_0001);
    rdrdy = 1;
    @(negedge clk); rdrdy = 0;
    chk("a_pop_vld", rdvld, 0);
    chk("a_pop_data", rddata, 0);

    // Source B read
    repeat (2) @(negedge clk);
    b_data = 32'h0000_0004; rdaddr = 8'h85; rdreq = 1;
    #1 chk("b_ack", rdack, 1);
    @(negedge clk); rdreq = 0;
    chk("b_rdb1", icerdb, 1);
    chk("b_rda1", icerda, 0);
    chk("b_adr", iceadr, 7'h05);
    @(negedge clk);
    chk("b_rdb2", icerdb, 1);
    @(negedge clk);
    chk("b_rdb3", icerdb, 0);
    chk("b_vld", rdvld, 1);
    chk("b_data", rddata, 32'h0000_0004);
    rdrdy = 1;
    @(negedge clk); rdrdy = 0;
    chk("b_pop_vld", rdvld, 0);

    // Back-to-back into a stalled buffer
    repeat (2) @(negedge clk);
    tag_mode = 1; rdaddr = 8'h01; rdreq = 1;
    #1 chk("f_ack1", rdack, 1);
    @(negedge clk); rdaddr = 8'h02;
    @(negedge clk);
    @(negedge clk);
    chk("f_guard_a", icerda, 0);
    chk("f_guard_b", icerdb, 0);
    chk("f_vld", rdvld, 1);
    #1 chk("f_ack2", rdack, 1);
    @(negedge clk); rdaddr = 8'h83;
    chk("f_rda", icerda, 1);
    chk("f_adr", iceadr, 7'h02);
    @(negedge clk);
    @(negedge clk);
    #1 chk("f_full_ack", rdack, 0);
    repeat (3) @(negedge clk);
    #1 chk("f_full_ack2", rdack, 0);
    chk("f_head", rddata, 32'hC0DE_0001);
    chk("f_stall_rda", icerda, 0);
    chk("f_stall_rdb", icerdb, 0);
    rdrdy = 1;
    @(negedge clk); rdrdy = 0;
    chk("f_head2", rddata, 32'hC0DE_0002);
    #1 chk("f_ack3", rdack, 1);
    @(negedge clk); rdreq = 0;
    chk("f_rdb", icerdb, 1);
    chk("f_adr3", iceadr, 7'h03);
    repeat (2) @(negedge clk);
    chk("f_vld2", rdvld, 1);
    chk("f_head3", rddata, 32'hC0DE_0002);
    rdrdy = 1;
    @(negedge clk);
    chk("f_head4", rddata, 32'hD0DE_0003);
    @(negedge clk); rdrdy = 0;
    chk("f_empty", rdvld, 0);

    // Idle bus error flag
    tag_mode = 0;
    repeat (3) @(negedge clk);
    chk("e_none", orerr, 0);
    force_v = 32'h1;
    @(negedge clk); force_v = 0;
    chk("e_set", orerr, 1);
    @(negedge clk);
    chk("e_hold", orerr, 1);
    clrerr = 1;
    @(negedge clk); clrerr = 0;
    chk("e_clr", orerr, 0);
    clrerr = 1; force_v = 32'h1;
    @(negedge clk); clrerr = 0; force_v = 0;
    chk("e_win", orerr, 1);
    clrerr = 1;
    @(negedge clk); clrerr = 0;
    chk("e_clr2", orerr, 0);

    // Reset in first strobe cycle
    a_data = 32'h1234_5678; rdaddr = 8'h05; rdreq = 1;
    #1 chk("r_ack", rdack, 1);
    @(negedge clk); rdreq = 0;
    chk("r_rda", icerda, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("r_rda0", icerda, 0);
    chk("r_rdb0", icerdb, 0);
    chk("r_adr0", iceadr, 0);
    chk("r_vld0", rdvld, 0);
    repeat (4) @(negedge clk);
    chk("r_vld1", rdvld, 0);
    chk("r_err", orerr, 0);
    rdrdy = 1;
    @(negedge clk); rdrdy = 0;
    chk("r_pop_empty", rdvld, 0);
    b_data = 32'h0000_0004; rdaddr = 8'h85; rdreq = 1;
    #1 chk("r_ack2", rdack, 1);
    @(negedge clk); rdreq = 0;
    chk("r_rdb", icerdb, 1);
    repeat (2) @(negedge clk);
    chk("r_vld2", rdvld, 1);
    chk("r_data", rddata, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
